case_3_dot_acc: RTL and testbench
=================================

# case_3_dot_acc

Streaming signed dot-product accumulator that sits directly downstream of the 5-bit signed product multiplier in the case_3 datapath. It consumes one product per accepted beat, sign-extends and sums LEN consecutive products, and presents each completed sum on a registered valid/ready output. It flags signed overflow per vector and applies backpressure to the multiplier stage when the output is not drained.

## Interface
- PROD_WIDTH, 5: width of the signed product input (matches the multiplier dout).
- ACC_WIDTH, 8: width of the signed accumulator and the sum output; must be ≥ PROD_WIDTH.
- LEN, 8: products per vector; must be ≥ 2.
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset; asynchronous, active-low.
- prod_data  in  PROD_WIDTH  signed product from the multiplier.
- prod_valid  in  1  prod_data is valid.
- prod_ready  out  1  block accepts prod_data this cycle.
- sum_data  out  ACC_WIDTH  completed signed sum (registered).
- sum_valid  out  1  sum_data/sum_ovf hold an unconsumed result.
- sum_ready  in  1  downstream accepts the result.
- sum_ovf  out  1  signed overflow occurred in this vector (registered, qualified by sum_valid).

## Operation
- Accept: prod_valid && prod_ready at a rising edge. Output handshake: sum_valid && sum_ready.
- Add: acc_next = acc + sext(prod_data), modulo 2^ACC_WIDTH (wrap, no saturation). Overflow on an add when both operands have the same sign and the result sign differs; ovf_acc is sticky across the vector.
- cnt counts accepted products in the current vector, 0..LEN-1.
- States: ACCUM, WAIT_OUT.
- ACCUM: prod_ready = 1. On a non-last accept (cnt < LEN-1), acc, ovf_acc and cnt update.
- ACCUM, last accept (cnt == LEN-1), output slot free (!sum_valid || sum_ready):
  - load sum_data = acc_next and sum_ovf = final ovf; set sum_valid = 1.
  - clear acc, ovf_acc and cnt; remain in ACCUM.
- ACCUM, last accept, slot occupied: keep acc = acc_next and the final ovf in ovf_acc; go to WAIT_OUT.
- WAIT_OUT: prod_ready = 0. When sum_ready is high:
  - transfer acc and ovf_acc into sum_data/sum_ovf; sum_valid stays 1.
  - clear acc, ovf_acc and cnt; return to ACCUM.
- Output handshake with no new load: sum_valid goes to 0. sum_data and sum_ovf hold their values.
- A simultaneous output handshake and last accept in ACCUM counts as a free slot: the new result loads and sum_valid stays 1.
- Reset (any cycle, including mid-vector or in WAIT_OUT):
  - state = ACCUM; acc = 0, cnt = 0, ovf_acc = 0.
  - sum_data = 0, sum_valid = 0, sum_ovf = 0.
  - prod_ready is forced to 0 while ap_rst_n is low; a partial vector is discarded.

## Timing
- Latency: the result is visible with sum_valid = 1 one cycle after the edge that accepts the last product.
- Throughput: one product per cycle when sum_ready keeps pace; no bubble between vectors.
- Stall: if the previous result is still held at the last accept, prod_ready drops the following cycle and stays low until the cycle sum_ready is high in WAIT_OUT. It returns to 1 on the next cycle.
- prod_ready depends only on state and ap_rst_n, never combinationally on prod_valid or sum_ready.
- sum_data, sum_valid and sum_ovf are driven directly from flops.

## Structure
- Shared package case_3_dot_acc_pkg holds:
  - the state enum (ACCUM, WAIT_OUT);
  - CNT_WIDTH = $clog2(LEN) as a function or localparam helper;
  - the overflow-detect function.
- One natural sub-module: case_3_dot_acc_add. It is combinational: sign-extend, ACC_WIDTH add, overflow bit out. It is instantiated once.
- Counter, FSM and output register live in the top module.

## Test plan
- LEN=4, sum_ready=1, products 3, -2, 7, -16 back-to-back -> sum_data=8'hF8 (-8), sum_ovf=0, sum_valid high for exactly 1 cycle, 1 cycle after the 4th accept.
- LEN=4, ACC_WIDTH=6, products 15, 15, 15, 15 -> sum_data=6'h3C (-4, wrapped), sum_ovf=1.
- LEN=4, sum_ready=0, two full vectors (all 1s, then all 2s):
  - first result 4 is held; prod_ready falls after the 8th accept;
  - raising sum_ready -> sum_data becomes 8 with sum_valid still 1, then prod_ready returns to 1.
- LEN=8, continuous valid with sum_ready toggling each cycle -> no product lost or duplicated; each sum equals the reference model's sum.
- Assert ap_rst_n low after 2 of 4 products (5, 5), then feed 1, 1, 1, 1 -> sum_data=4. All outputs are 0 during reset.
- Simultaneous output handshake and last accept in ACCUM -> new result loads and sum_valid stays 1 with no gap cycle.

Source files
------------

// File: rtl/case_3_dot_acc_pkg.sv
// case_3_dot_acc_pkg: shared state type, counter sizing and overflow rule for the dot-product accumulator
package case_3_dot_acc_pkg;

    typedef enum logic {ACCUM, WAIT_OUT} state_t;

    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    // Two's-complement add overflows when equal-signed operands yield a differently-signed result.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/case_3_dot_acc_add.sv
// case_3_dot_acc_add: sign-extends one product and adds it to the accumulator, flagging signed overflow
module case_3_dot_acc_add
    import case_3_dot_acc_pkg::*;
#(
    parameter int PROD_WIDTH = 5,
    parameter int ACC_WIDTH  = 8
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [PROD_WIDTH-1:0] prod,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  ovf
);

    logic [ACC_WIDTH-1:0] ext;

    always_comb begin
        ext = ACC_WIDTH'($signed(prod));
        sum = acc + ext;
        ovf = add_ovf(acc[ACC_WIDTH-1], ext[ACC_WIDTH-1], sum[ACC_WIDTH-1]);
    end

endmodule

// File: rtl/case_3_dot_acc.sv
// case_3_dot_acc: streaming signed dot-product accumulator with registered valid/ready result and sticky overflow
module case_3_dot_acc
    import case_3_dot_acc_pkg::*;
#(
    parameter int PROD_WIDTH = 5,
    parameter int ACC_WIDTH  = 8,
    parameter int LEN        = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [ACC_WIDTH-1:0]  sum_data,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic                  sum_ovf
);

    localparam int CNT_WIDTH = cnt_width(LEN);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LEN - 1);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf_acc;
    logic                 step_ovf;
    logic                 ovf_next;
    logic                 accept;
    logic                 last;
    logic                 slot_free;

    case_3_dot_acc_add #(
        .PROD_WIDTH(PROD_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .acc (acc),
        .prod(prod_data),
        .sum (acc_next),
        .ovf (step_ovf)
    );

    always_comb begin
        prod_ready = ap_rst_n && (state == ACCUM);
        accept     = prod_valid && prod_ready;
        last       = (cnt == LAST);
        slot_free  = !sum_valid || sum_ready;
        ovf_next   = ovf_acc || step_ovf;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            sum_data  <= '0;
            sum_valid <= 1'b0;
            sum_ovf   <= 1'b0;
        end else if (state == WAIT_OUT) begin
            // Held vector moves into the output slot as the previous result drains.
            if (sum_ready) begin
                sum_data  <= acc;
                sum_ovf   <= ovf_acc;
                sum_valid <= 1'b1;
                acc       <= '0;
                ovf_acc   <= 1'b0;
                cnt       <= '0;
                state     <= ACCUM;
            end
        end else begin
            if (sum_valid && sum_ready)
                sum_valid <= 1'b0;
            if (accept) begin
                if (!last) begin
                    acc     <= acc_next;
                    ovf_acc <= ovf_next;
                    cnt     <= cnt + 1'b1;
                end else if (slot_free) begin
                    sum_data  <= acc_next;
                    sum_ovf   <= ovf_next;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    ovf_acc   <= 1'b0;
                    cnt       <= '0;
                end else begin
                    acc     <= acc_next;
                    ovf_acc <= ovf_next;
                    state   <= WAIT_OUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_case_3_dot_acc.sv
// tb_case_3_dot_acc: directed and random checks of three accumulator configurations against an arithmetic scoreboard
module tb_case_3_dot_acc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] pd = '0;
    logic       pv = 1'b0;
    logic       srdy = 1'b1;
    logic [2:0] rdy, sv, so;
    logic [7:0] sd_a, sd_c;
    logic [5:0] sd_b;
    logic [7:0] sd [3];

    int passed = 0;
    int failed = 0;
    int total = 0;

    int lenv [3] = '{4, 4, 8};
    int wv   [3] = '{8, 6, 8};
    int racc [3] = '{0, 0, 0};
    int rcnt [3] = '{0, 0, 0};
    int rovf [3] = '{0, 0, 0};
    int wr   [3] = '{0, 0, 0};
    int rd   [3] = '{0, 0, 0};
    logic [8:0] exp_mem [3][64];

    always #5 clk = ~clk;

    assign sd[0] = sd_a;
    assign sd[1] = {2'b00, sd_b};
    assign sd[2] = sd_c;

    case_3_dot_acc #(.PROD_WIDTH(5), .ACC_WIDTH(8), .LEN(4)) dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .prod_data(pd), .prod_valid(pv), .prod_ready(rdy[0]),
        .sum_data(sd_a), .sum_valid(sv[0]), .sum_ready(srdy), .sum_ovf(so[0]));

    case_3_dot_acc #(.PROD_WIDTH(5), .ACC_WIDTH(6), .LEN(4)) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .prod_data(pd), .prod_valid(pv), .prod_ready(rdy[1]),
        .sum_data(sd_b), .sum_valid(sv[1]), .sum_ready(srdy), .sum_ovf(so[1]));

    case_3_dot_acc #(.PROD_WIDTH(5), .ACC_WIDTH(8), .LEN(8)) dut_c (
        .ap_clk(clk), .ap_rst_n(rst_n), .prod_data(pd), .prod_valid(pv), .prod_ready(rdy[2]),
        .sum_data(sd_c), .sum_valid(sv[2]), .sum_ready(srdy), .sum_ovf(so[2]));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input logic r);
        pd = 5'(v);
        pv = 1'b1;
        srdy = r;
        step();
    endtask

    // Scoreboard: inputs and outputs are stable from the falling edge to the next rising edge,
    // so handshakes seen here are the ones that complete at that rising edge.
    always @(negedge clk) begin
        int p, v, lo, hi, mask;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                racc[i] = 0;
                rcnt[i] = 0;
                rovf[i] = 0;
                rd[i] = wr[i];
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sv[i] && srdy) begin
                    chk($sformatf("sb_pending%0d", i), 16'(wr[i] > rd[i]), 16'd1);
                    if (wr[i] > rd[i]) begin
                        chk($sformatf("sb_sum%0d", i), {7'd0, so[i], sd[i]}, {7'd0, exp_mem[i][rd[i] % 64]});
                        rd[i]++;
                    end
                end
                if (pv && rdy[i]) begin
                    p = $signed(pd);
                    lo = -(1 << (wv[i] - 1));
                    hi = (1 << (wv[i] - 1)) - 1;
                    mask = (1 << wv[i]) - 1;
                    v = racc[i] + p;
                    if (v > hi || v < lo) rovf[i] = 1;
                    v = v & mask;
                    if (v > hi) v = v - (1 << wv[i]);
                    racc[i] = v;
                    rcnt[i]++;
                    if (rcnt[i] == lenv[i]) begin
                        exp_mem[i][wr[i] % 64] = {rovf[i][0], 8'(racc[i] & mask)};
                        wr[i]++;
                        racc[i] = 0;
                        rcnt[i] = 0;
                        rovf[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 16'(sv), 16'd0);
        chk("rst_ready", 16'(rdy), 16'd0);
        chk("rst_data", 16'(sd_a), 16'd0);
        chk("rst_ovf", 16'(so), 16'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 16'(rdy), 16'h7);

        // 3, -2, 7, -16 -> -8
        send(3, 1); send(-2, 1); send(7, 1); send(-16, 1);
        pv = 1'b0;
        chk("t1_valid", 16'(sv[0]), 16'd1);
        chk("t1_data_a", 16'(sd_a), 16'h00F8);
        chk("t1_ovf_a", 16'(so[0]), 16'd0);
        chk("t1_data_b", 16'(sd_b), 16'h0038);
        step();
        chk("t1_valid_one_cycle", 16'(sv[0]), 16'd0);

        // 15 x4 -> wraps in 6 bits only
        for (int k = 0; k < 4; k++) send(15, 1);
        pv = 1'b0;
        chk("t2_data_a", 16'(sd_a), 16'h003C);
        chk("t2_ovf_a", 16'(so[0]), 16'd0);
        chk("t2_data_b", 16'(sd_b), 16'h003C);
        chk("t2_ovf_b", 16'(so[1]), 16'd1);
        step();

        // Backpressure: two vectors with the output not drained
        for (int k = 0; k < 4; k++) send(1, 0);
        for (int k = 0; k < 4; k++) send(2, 0);
        pv = 1'b0;
        chk("t3_stall_ready", 16'(rdy[0]), 16'd0);
        chk("t3_held_data", 16'(sd_a), 16'd4);
        chk("t3_held_valid", 16'(sv[0]), 16'd1);
        step();
        chk("t3_still_stalled", 16'(rdy[0]), 16'd0);
        srdy = 1'b1;
        step();
        chk("t3_second_data", 16'(sd_a), 16'd8);
        chk("t3_second_valid", 16'(sv[0]), 16'd1);
        chk("t3_ready_back", 16'(rdy[0]), 16'd1);
        chk("t3_second_data_b", 16'(sd_b), 16'd8);
        step();
        chk("t3_drained", 16'(sv[0]), 16'd0);
        chk("t3_data_holds", 16'(sd_a), 16'd8);

        // Output handshake coinciding with the last accept
        send(1, 1); send(2, 1); send(3, 1); send(4, 1);
        for (int k = 0; k < 4; k++) begin
            send(5, k == 3);
            if (k == 2) begin
                chk("t4_old_valid", 16'(sv[0]), 16'd1);
                chk("t4_old_data", 16'(sd_a), 16'd10);
            end
        end
        pv = 1'b0;
        chk("t4_new_data", 16'(sd_a), 16'd20);
        chk("t4_no_gap", 16'(sv[0]), 16'd1);
        chk("t4_ready", 16'(rdy[0]), 16'd1);
        step();

        // Reset in the middle of a vector
        send(5, 1); send(5, 1);
        pv = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 16'(rdy), 16'd0);
        chk("t5_rst_valid", 16'(sv), 16'd0);
        chk("t5_rst_data_a", 16'(sd_a), 16'd0);
        chk("t5_rst_data_c", 16'(sd_c), 16'd0);
        chk("t5_rst_ovf", 16'(so), 16'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) send(1, 1);
        pv = 1'b0;
        chk("t5_data", 16'(sd_a), 16'd4);
        chk("t5_valid", 16'(sv[0]), 16'd1);
        chk("t5_ovf", 16'(so[0]), 16'd0);
        step();

        // Random products, random valid, sum_ready toggling every cycle
        for (int k = 0; k < 400; k++) begin
            pd = 5'($urandom);
            pv = ($urandom_range(0, 3) != 0);
            srdy = ~srdy;
            step();
        end
        pv = 1'b0;
        srdy = 1'b1;
        repeat (6) step();
        for (int i = 0; i < 3; i++)
            chk($sformatf("drain%0d", i), 16'(wr[i] - rd[i]), 16'd0);
        chk("random_results_seen", 16'(wr[2] > 20), 16'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
